// File: rtl/key_channel_selector_pkg.sv
// Shared types and helpers for the key-driven channel selector.
package key_channel_selector_pkg;

  // Per-key auto-repeat FSM states
  typedef enum logic [1:0] {
    KS_IDLE   = 2'd0,
    KS_PRESS  = 2'd1,
    KS_REPEAT = 2'd2
  } key_state_e;

  // Bits needed to hold 0..v-1, never less than one bit
  function automatic int clog2w(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Debouncer for one raw active-low key: two-flop synchronizer, stable-time
// filter, and a one-cycle press pulse on each debounced released->pressed edge.
// Press pulses are withheld until the key has been seen released once since
// reset, so a key held through reset cannot step until it is pressed again.
module key_debounce
  import key_channel_selector_pkg::*;
#(
  parameter int HOLD_TIME = 2_000_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic key_n,
  output logic press,
  output logic level
);

  localparam int              CNT_W    = clog2w(HOLD_TIME);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_TIME - 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             armed_q, armed_d;
  logic             smp;

  // Synchronized sample, active-high "pressed"
  assign smp = sync_q[1];

  // Count consecutive samples disagreeing with the debounced level; flip on the last
  always_comb begin
    sync_d  = {sync_q[0], ~key_n};
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    armed_d = armed_q | ~smp;
    if (smp != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = smp;
        press_d = smp & armed_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; synchronizer resets to "pressed" so nothing arms before a real release is seen
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      armed_q <= armed_d;
    end
  end

  assign press = press_q;
  assign level = level_q;

endmodule

// File: rtl/key_channel_selector.sv
// Channel selector: two debounced keys step a wrapping channel index up/down,
// with long-hold auto-repeat, a priority load port and a change pulse.
module key_channel_selector
  import key_channel_selector_pkg::*;
#(
  parameter int CH_NUM      = 4,
  parameter int CH_W        = 4,
  parameter int HOLD_TIME   = 2_000_000,
  parameter int LONG_TIME   = 50_000_000,
  parameter int REPEAT_TIME = 10_000_000
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            key_next,
  input  logic            key_prev,
  input  logic            ch_load,
  input  logic [CH_W-1:0] ch_load_val,
  output logic [CH_W-1:0] read_channel,
  output logic            ch_changed
);

  localparam int               HC_MAX    = (LONG_TIME > REPEAT_TIME) ? LONG_TIME : REPEAT_TIME;
  localparam int               HC_W      = clog2w(HC_MAX);
  localparam logic [HC_W-1:0]  LONG_LAST = HC_W'(LONG_TIME - 1);
  localparam logic [HC_W-1:0]  REP_LAST  = HC_W'(REPEAT_TIME - 1);
  localparam logic [CH_W-1:0]  CH_MAX    = CH_W'(CH_NUM - 1);

  // Index 0 = next key, index 1 = prev key
  logic [1:0]      press, level, step;
  key_state_e      state_q [2];
  key_state_e      state_d [2];
  logic [HC_W-1:0] hcnt_q  [2];
  logic [HC_W-1:0] hcnt_d  [2];
  logic [CH_W-1:0] ch_q, ch_d;
  logic            changed_q, changed_d;

  key_debounce #(.HOLD_TIME(HOLD_TIME)) u_db_next (
    .clk   (clk),
    .rstn  (rstn),
    .key_n (key_next),
    .press (press[0]),
    .level (level[0])
  );

  key_debounce #(.HOLD_TIME(HOLD_TIME)) u_db_prev (
    .clk   (clk),
    .rstn  (rstn),
    .key_n (key_prev),
    .press (press[1]),
    .level (level[1])
  );

  // FSM state and hold-counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < 2; k++) begin
        state_q[k] <= KS_IDLE;
        hcnt_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        state_q[k] <= state_d[k];
        hcnt_q[k]  <= hcnt_d[k];
      end
    end
  end

  // Next state: the hold counter reloads on every terminal count, so it never wraps
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      state_d[k] = state_q[k];
      hcnt_d[k]  = hcnt_q[k];
      case (state_q[k])
        KS_IDLE: begin
          if (press[k]) begin
            state_d[k] = KS_PRESS;
            hcnt_d[k]  = '0;
          end
        end
        KS_PRESS: begin
          if (!level[k]) begin
            state_d[k] = KS_IDLE;
            hcnt_d[k]  = '0;
          end else if (hcnt_q[k] == LONG_LAST) begin
            state_d[k] = KS_REPEAT;
            hcnt_d[k]  = '0;
          end else begin
            hcnt_d[k] = hcnt_q[k] + HC_W'(1);
          end
        end
        KS_REPEAT: begin
          if (!level[k]) begin
            state_d[k] = KS_IDLE;
            hcnt_d[k]  = '0;
          end else if (hcnt_q[k] == REP_LAST) begin
            hcnt_d[k] = '0;
          end else begin
            hcnt_d[k] = hcnt_q[k] + HC_W'(1);
          end
        end
        default: begin
          state_d[k] = KS_IDLE;
          hcnt_d[k]  = '0;
        end
      endcase
    end
  end

  // FSM outputs: one step request per press, long-hold entry and repeat tick
  always_comb begin
    step = '0;
    for (int k = 0; k < 2; k++) begin
      case (state_q[k])
        KS_IDLE:   step[k] = press[k];
        KS_PRESS:  step[k] = level[k] && (hcnt_q[k] == LONG_LAST);
        KS_REPEAT: step[k] = level[k] && (hcnt_q[k] == REP_LAST);
        default:   step[k] = 1'b0;
      endcase
    end
  end

  // Channel update: load wins over steps, out-of-range loads are dropped, opposing steps cancel
  always_comb begin
    ch_d = ch_q;
    if (ch_load) begin
      if (ch_load_val <= CH_MAX) ch_d = ch_load_val;
    end else if (step == 2'b01) begin
      ch_d = (ch_q == CH_MAX) ? '0 : ch_q + CH_W'(1);
    end else if (step == 2'b10) begin
      ch_d = (ch_q == '0) ? CH_MAX : ch_q - CH_W'(1);
    end
    changed_d = (ch_d != ch_q);
  end

  // Channel register and change pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ch_q      <= '0;
      changed_q <= 1'b0;
    end else begin
      ch_q      <= ch_d;
      changed_q <= changed_d;
    end
  end

  assign read_channel = ch_q;
  assign ch_changed   = changed_q;

endmodule

// File: tb/tb_key_channel_selector.sv
// Randomized and directed bench for key_channel_selector with a cycle-level
// behavioural model (sample window debounce, hold-age based repeat schedule).
module tb_key_channel_selector;

  localparam int CH     = 4;
  localparam int CW     = 4;
  localparam int HOLD_T = 4;
  localparam int LONG_T = 20;
  localparam int REP_T  = 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          key_next = 1'b1;
  logic          key_prev = 1'b1;
  logic          ch_load = 1'b0;
  logic [CW-1:0] ch_load_val = '0;
  logic [CW-1:0] read_channel;
  logic          ch_changed;

  int checks = 0;
  int errors = 0;
  int chg_cnt = 0;

  key_channel_selector #(
    .CH_NUM(CH), .CH_W(CW), .HOLD_TIME(HOLD_T),
    .LONG_TIME(LONG_T), .REPEAT_TIME(REP_T)
  ) dut (
    .clk(clk), .rstn(rstn), .key_next(key_next), .key_prev(key_prev),
    .ch_load(ch_load), .ch_load_val(ch_load_val),
    .read_channel(read_channel), .ch_changed(ch_changed)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_ch;
  bit m_chg;
  bit dl   [2][2];      // two-sample input latency
  bit win  [2][HOLD_T]; // most recent HOLD_T latent samples
  bit lvl  [2];
  bit pls  [2];
  bit arm  [2];
  bit act  [2];
  int age  [2];         // cycles since the press step
  bit stp  [2];
  bit pin  [2];
  bit s2, all_diff, np;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_ch = 0; m_chg = 0;
      for (int k = 0; k < 2; k++) begin
        dl[k][0] = 1; dl[k][1] = 1;
        for (int i = 0; i < HOLD_T; i++) win[k][i] = 0;
        lvl[k] = 0; pls[k] = 0; arm[k] = 0; act[k] = 0; age[k] = 0;
      end
    end else begin
      pin[0] = !key_next;
      pin[1] = !key_prev;
      for (int k = 0; k < 2; k++) begin
        stp[k] = 0;
        if (act[k]) begin
          if (!lvl[k]) act[k] = 0;
          else begin
            age[k]++;
            if (age[k] == LONG_T || (age[k] > LONG_T && (age[k] - LONG_T) % REP_T == 0))
              stp[k] = 1;
          end
        end else if (pls[k]) begin
          act[k] = 1; age[k] = 0; stp[k] = 1;
        end
        s2 = dl[k][1]; dl[k][1] = dl[k][0]; dl[k][0] = pin[k];
        for (int i = 0; i < HOLD_T - 1; i++) win[k][i] = win[k][i+1];
        win[k][HOLD_T-1] = s2;
        all_diff = 1;
        for (int i = 0; i < HOLD_T; i++) if (win[k][i] == lvl[k]) all_diff = 0;
        np = 0;
        if (all_diff) begin
          lvl[k] = !lvl[k];
          np = lvl[k] && arm[k];
        end
        if (!s2) arm[k] = 1;
        pls[k] = np;
      end
      if (ch_load) begin
        if (int'(ch_load_val) < CH && int'(ch_load_val) != m_ch) begin
          m_ch = int'(ch_load_val); m_chg = 1;
        end else m_chg = 0;
      end else if (stp[0] != stp[1]) begin
        m_ch  = stp[0] ? (m_ch + 1) % CH : (m_ch + CH - 1) % CH;
        m_chg = 1;
      end else m_chg = 0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    checks++;
    if (int'(read_channel) != m_ch || ch_changed !== m_chg || int'(read_channel) >= CH) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t: ch=%0d chg=%0b expected ch=%0d chg=%0b",
               $time, read_channel, ch_changed, m_ch, m_chg);
    end
    if (ch_changed === 1'b1) chg_cnt++;
  end

  // ---------------- helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input int act_v, input int exp_v);
    checks++;
    if (act_v != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act_v, exp_v);
    end
  endtask

  task automatic tap(input bit nx, input bit pv, input int hold, input int gap);
    if (nx) key_next = 1'b0;
    if (pv) key_prev = 1'b0;
    cyc(hold);
    key_next = 1'b1;
    key_prev = 1'b1;
    cyc(gap);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    cyc(2);
    rstn = 1'b1;
    cyc(6);
  endtask

  int exp5 [5] = '{1, 2, 3, 0, 1};
  int c0;

  initial begin
    // reset state
    cyc(3);
    chk("rst_channel", int'(read_channel), 0);
    chk("rst_changed", int'(ch_changed), 0);
    rstn = 1'b1;
    cyc(8);

    // five short next presses
    for (int i = 0; i < 5; i++) begin
      c0 = chg_cnt;
      tap(1, 0, 10, 12);
      chk($sformatf("next_tap%0d", i), int'(read_channel), exp5[i]);
      chk($sformatf("next_tap%0d_pulses", i), chg_cnt - c0, 1);
    end

    // prev from 0 wraps, then a short glitch is filtered
    do_reset();
    tap(0, 1, 10, 12);
    chk("prev_wrap", int'(read_channel), 3);
    c0 = chg_cnt;
    tap(0, 1, 3, 12);
    chk("glitch_channel", int'(read_channel), 3);
    chk("glitch_pulses", chg_cnt - c0, 0);

    // 40-cycle hold: press, long-hold and three repeats = 5 steps
    do_reset();
    c0 = chg_cnt;
    tap(1, 0, 40, 20);
    chk("hold40_channel", int'(read_channel), 1);
    chk("hold40_pulses", chg_cnt - c0, 5);

    // load overriding a concurrent next step
    do_reset();
    c0 = chg_cnt;
    key_next = 1'b0;
    cyc(3);
    ch_load = 1'b1; ch_load_val = 4'd2;
    cyc(6);
    ch_load = 1'b0;
    key_next = 1'b1;
    cyc(15);
    chk("load_vs_step", int'(read_channel), 2);
    chk("load_vs_step_pulses", chg_cnt - c0, 1);
    // out-of-range load
    c0 = chg_cnt;
    ch_load = 1'b1; ch_load_val = 4'd5; cyc(1); ch_load = 1'b0; cyc(3);
    chk("load_oob", int'(read_channel), 2);
    chk("load_oob_pulses", chg_cnt - c0, 0);
    // same-value load
    ch_load = 1'b1; ch_load_val = 4'd2; cyc(1); ch_load = 1'b0; cyc(3);
    chk("load_same_pulses", chg_cnt - c0, 0);

    // both keys together cancel
    c0 = chg_cnt;
    tap(1, 1, 10, 15);
    chk("both_keys", int'(read_channel), 2);
    chk("both_keys_pulses", chg_cnt - c0, 0);

    // reset in the middle of a hold
    key_next = 1'b0;
    cyc(30);
    rstn = 1'b0;
    cyc(2);
    chk("midhold_rst", int'(read_channel), 0);
    rstn = 1'b1;
    c0 = chg_cnt;
    cyc(40);
    chk("after_rst_held", int'(read_channel), 0);
    chk("after_rst_held_pulses", chg_cnt - c0, 0);
    key_next = 1'b1;
    cyc(15);
    tap(1, 0, 10, 12);
    chk("repress_after_rst", int'(read_channel), 1);

    // randomized traffic checked cycle by cycle against the model
    for (int seg = 0; seg < 150; seg++) begin
      key_next    = ($urandom_range(0, 2) != 0);
      key_prev    = ($urandom_range(0, 2) != 0);
      ch_load     = ($urandom_range(0, 5) == 0);
      ch_load_val = CW'($urandom_range(0, 7));
      if ($urandom_range(0, 60) == 0) rstn = 1'b0;
      cyc(1);
      ch_load = 1'b0;
      rstn    = 1'b1;
      cyc($urandom_range(1, 35));
    end
    key_next = 1'b1;
    key_prev = 1'b1;
    cyc(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
